mem_dma_copy: RTL and testbench
===============================

// Module: mem_dma_copy
// PURPOSE
//   Initiator end of the memory interface: word-granular copy engine that drives a
//   single_port_ram-style responder (enable, 4-bit byte-write mask, combinational read).
//   Copies LEN 32-bit words from SRC to DST, one read cycle then one write cycle per word.
//   Sits between a control master (core or test sequencer) and the shared data memory.
// PARAMETERS
//   MEMORY_BUS_WIDTH  32  data width of the memory port; only 32 is supported
//   ADDR_WIDTH        32  byte-address width; address arithmetic wraps modulo 2**ADDR_WIDTH
//   LEN_WIDTH         16  width of the word-count input and the progress counter
// PORTS
//   clock        in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   start_in     in   1          one-cycle request; sampled only in IDLE
//   abort_in     in   1          terminate the current copy
//   src_in       in   ADDR_WIDTH source byte address; must be 4-byte aligned
//   dst_in       in   ADDR_WIDTH destination byte address; must be 4-byte aligned
//   len_in       in   LEN_WIDTH  number of words to copy
//   busy_out     out  1          copy in progress
//   done_out     out  1          one-cycle pulse on normal completion
//   error_out    out  1          one-cycle pulse when start_in is rejected for misalignment
//   aborted_out  out  1          one-cycle pulse when a copy is terminated by abort_in
//   count_out    out  LEN_WIDTH  words written in the current or last copy
//   mem_enable_out  out 1        memory enable
//   mem_wb_out      out 4        byte-write mask; 4'b0000 = read, 4'b1111 = full-word write
//   mem_addr_out    out ADDR_WIDTH memory byte address
//   mem_data_out    out 32       write data
//   mem_data_in     in  32       read data; combinational from mem_addr_out, same cycle
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0: busy, done, error, aborted, count, mem_enable,
//     mem_wb, mem_addr, mem_data. Mid-copy reset drops mem_enable at once; a write not
//     yet clocked is lost.
//   All mem_* outputs are registered from FSM state; nothing is combinational from inputs.
//   FSM states: IDLE, READ, WRITE, DONE.
//   IDLE: on start_in:
//     - src_in[1:0] or dst_in[1:0] nonzero -> error_out pulses the next cycle; stay IDLE.
//     - len_in==0 -> DONE; no memory access; count_out cleared.
//     - otherwise latch src, dst, len; clear count; -> READ.
//   READ: mem_enable=1, mem_wb=0000, mem_addr=src. At the closing edge capture mem_data_in
//     into buf; src+=4 -> WRITE.
//   WRITE: mem_enable=1, mem_wb=1111, mem_addr=dst, mem_data=byte-reverse(buf).
//     At the closing edge dst+=4, count+=1, remaining-=1; remaining==0 -> DONE, else READ.
//     The responder returns reads as {m[a+3],m[a+2],m[a+1],m[a]} and writes data[31:24]
//     to m[a]. byte-reverse({b3,b2,b1,b0}) = {b0,b1,b2,b3} makes destination bytes equal
//     source bytes in order.
//   DONE: one cycle; done_out=1, busy_out=0, mem_enable=0 -> IDLE.
//   busy_out=1 exactly while the state is READ or WRITE.
//   Timing: start sampled at edge 0 -> READ in cycle 1, WRITE in cycle 2 ... last WRITE in
//     cycle 2N, done_out in cycle 2N+1. Throughput: 2 cycles/word.
//   start_in outside IDLE is ignored; no queuing.
//   abort_in sampled high at an edge in READ or WRITE:
//     - the access presented in that cycle completes; a WRITE is committed and counted;
//     - next state IDLE; aborted_out pulses one cycle; done_out is not asserted.
//   abort_in in IDLE or DONE has no effect. abort_in and start_in together in IDLE:
//     start wins.
//   Overlapping src/dst ranges: copy runs in ascending address order; no overlap handling.
//   Address wrap past 2**ADDR_WIDTH-4 wraps to 0 with no error.
// TESTING
//   1. Preload words 0x100..0x10C = 11223344,55667788,99AABBCC,DDEEFF00; start src=0x100
//      dst=0x200 len=4 -> 4 writes mask 1111, bytes at 0x200..0x20F equal source bytes,
//      done_out at cycle 9, count_out=4.
//   2. start with len=0 -> no mem_enable activity; done_out one cycle later; count_out=0.
//   3. start with src=0x102 -> error_out pulse; busy_out stays 0; no memory access.
//   4. len=8; assert abort_in at the 3rd WRITE cycle -> exactly 3 words written,
//      aborted_out pulse, count_out=3, dst+12 onward unchanged.
//   5. Reset asserted during a WRITE of a len=4 copy -> all outputs 0 immediately;
//      that word is not written; a subsequent start copies normally.
//   6. start_in pulsed while busy -> ignored; the first copy's count and done are unaffected.

Source files
------------

// File: rtl/mem_dma_copy.sv
// Word-granular memory copy engine: one read cycle then one write cycle per word.
// Drives a single-port RAM with byte-write mask and combinational read data.
module mem_dma_copy #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic [ADDR_WIDTH-1:0]       src_in,
    input  logic [ADDR_WIDTH-1:0]       dst_in,
    input  logic [LEN_WIDTH-1:0]        len_in,
    output logic                        busy_out,
    output logic                        done_out,
    output logic                        error_out,
    output logic                        aborted_out,
    output logic [LEN_WIDTH-1:0]        count_out,
    output logic                        mem_enable_out,
    output logic [3:0]                  mem_wb_out,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [LEN_WIDTH-1:0]    count_q, count_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    aborted_q, aborted_d;
    logic                    en_q, en_d;
    logic [3:0]              wb_q, wb_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [MEMORY_BUS_WIDTH-1:0] data_q, data_d;
    logic [MEMORY_BUS_WIDTH-1:0] rd_rev;

    // Responder reads little-endian but writes data[31:24] to the lowest byte.
    assign rd_rev = {mem_data_in[7:0], mem_data_in[15:8],
                     mem_data_in[23:16], mem_data_in[31:24]};

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        count_d   = count_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        aborted_d = 1'b0;
        en_d      = 1'b0;
        wb_d      = 4'b0000;
        addr_d    = '0;
        data_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    if ((src_in[1:0] != 2'b00) || (dst_in[1:0] != 2'b00)) begin
                        error_d = 1'b1;
                    end else if (len_in == '0) begin
                        state_d = DONE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        src_d   = src_in;
                        dst_d   = dst_in;
                        rem_d   = len_in;
                        count_d = '0;
                        state_d = READ;
                        en_d    = 1'b1;
                        addr_d  = src_in;
                    end
                end
            end
            READ: begin
                src_d = src_q + ADDR_WIDTH'(4);
                if (abort_in) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = WRITE;
                    en_d    = 1'b1;
                    wb_d    = 4'b1111;
                    addr_d  = dst_q;
                    data_d  = rd_rev;
                end
            end
            WRITE: begin
                dst_d   = dst_q + ADDR_WIDTH'(4);
                count_d = count_q + LEN_WIDTH'(1);
                rem_d   = rem_q - LEN_WIDTH'(1);
                if (abort_in) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                    en_d    = 1'b1;
                    addr_d  = src_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == READ) || (state_d == WRITE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            en_q      <= 1'b0;
            wb_q      <= 4'b0000;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
            en_q      <= en_d;
            wb_q      <= wb_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign error_out      = error_q;
    assign aborted_out    = aborted_q;
    assign count_out      = count_q;
    assign mem_enable_out = en_q;
    assign mem_wb_out     = wb_q;
    assign mem_addr_out   = addr_q;
    assign mem_data_out   = data_q;

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed bench for mem_dma_copy with a byte-addressed single-port RAM model.
// Table-driven copies plus abort and mid-write reset sequences.
module tb_mem_dma_copy;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [31:0] src_in = '0;
    logic [31:0] dst_in = '0;
    logic [15:0] len_in = '0;
    logic        busy_out, done_out, error_out, aborted_out;
    logic [15:0] count_out;
    logic        mem_enable_out;
    logic [3:0]  mem_wb_out;
    logic [31:0] mem_addr_out, mem_data_out, mem_data_in;

    mem_dma_copy dut (
        .clock(clock), .reset(reset),
        .start_in(start_in), .abort_in(abort_in),
        .src_in(src_in), .dst_in(dst_in), .len_in(len_in),
        .busy_out(busy_out), .done_out(done_out),
        .error_out(error_out), .aborted_out(aborted_out),
        .count_out(count_out),
        .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in)
    );

    always #5 clock = ~clock;

    logic [7:0]  m [0:1023];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_a = '0;
    logic [31:0] ld_w = '0;
    logic [9:0]  ra;

    assign ra = mem_addr_out[9:0];
    assign mem_data_in = {m[ra + 10'd3], m[ra + 10'd2], m[ra + 10'd1], m[ra]};

    always @(posedge clock) begin
        if (ld_en) begin
            m[ld_a]         <= ld_w[7:0];
            m[ld_a + 10'd1] <= ld_w[15:8];
            m[ld_a + 10'd2] <= ld_w[23:16];
            m[ld_a + 10'd3] <= ld_w[31:24];
        end else if (mem_enable_out) begin
            for (int b = 0; b < 4; b++)
                if (mem_wb_out[3-b])
                    m[ra + 10'(b)] <= mem_data_out[31-8*b -: 8];
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        @(negedge clock);
        ld_en = 1'b1;
        ld_a  = a[9:0];
        ld_w  = w;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {m[i + 10'd3], m[i + 10'd2], m[i + 10'd1], m[i]};
    endfunction

    function automatic logic [31:0] srcword(input int v, input int i);
        if (v == 0) begin
            case (i)
                0: return 32'h11223344;
                1: return 32'h55667788;
                2: return 32'h99AABBCC;
                default: return 32'hDDEEFF00;
            endcase
        end
        return {8'(v + 1), 8'(i), 8'hC3, 8'(i * 7 + 1)};
    endfunction

    // Leaves the bench at the falling edge of cycle 1.
    task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] n);
        @(negedge clock);
        src_in   = s;
        dst_in   = d;
        len_in   = n;
        start_in = 1'b1;
        @(negedge clock);
        start_in = 1'b0;
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        bit          restart;
        bit          exp_err;
        int          exp_done;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tv [6];

    task automatic run_vec(input int v);
        vec_t t;
        int   cyc, last, done_cyc, err_cyc, en_n, wr_n, nw;
        bit   busy_seen, ok;
        t = tv[v];
        for (int i = 0; i < int'(t.len); i++)
            poke(t.src + 32'(4 * i), srcword(v, i));
        for (int i = 0; i <= int'(t.len); i++)
            poke(t.dst + 32'(4 * i), 32'hDEADBEEF);
        start_copy(t.src, t.dst, t.len);
        cyc = 1; done_cyc = 0; err_cyc = 0; en_n = 0; wr_n = 0;
        busy_seen = 1'b0;
        last = 2 * int'(t.len) + 4;
        while (cyc <= last) begin
            if (done_out && done_cyc == 0) done_cyc = cyc;
            if (error_out && err_cyc == 0) err_cyc = cyc;
            if (busy_out) busy_seen = 1'b1;
            if (mem_enable_out) en_n++;
            if (mem_enable_out && mem_wb_out == 4'hF) wr_n++;
            if (t.restart && cyc == 3) begin
                start_in = 1'b1;
                src_in   = 32'h0;
                dst_in   = 32'h3F0;
                len_in   = 16'd2;
            end else begin
                start_in = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start_in = 1'b0;
        nw = t.exp_err ? 0 : int'(t.len);
        check($sformatf("v%0d error cycle", v), err_cyc, t.exp_err ? 1 : 0);
        check($sformatf("v%0d done cycle", v), done_cyc, t.exp_done);
        check($sformatf("v%0d count", v), count_out, t.exp_cnt);
        check($sformatf("v%0d busy seen", v), busy_seen, nw != 0);
        check($sformatf("v%0d enable cycles", v), en_n, 2 * nw);
        check($sformatf("v%0d writes", v), wr_n, nw);
        if (nw != 0) begin
            ok = 1'b1;
            for (int i = 0; i < nw; i++)
                if (peek(t.dst + 32'(4 * i)) !== srcword(v, i)) ok = 1'b0;
            check($sformatf("v%0d dest data", v), ok, 1);
        end
        check($sformatf("v%0d guard word", v),
              peek(t.dst + 32'(4 * nw)), 32'hDEADBEEF);
    endtask

    initial begin
        int cyc, ab_cyc, done_n, wr_n;
        bit ok;

        tv[0] = '{32'h100, 32'h200, 16'd4, 1'b0, 1'b0, 9, 16'd4};
        tv[1] = '{32'h000, 32'h010, 16'd0, 1'b0, 1'b0, 1, 16'd0};
        tv[2] = '{32'h102, 32'h220, 16'd3, 1'b0, 1'b1, 0, 16'd0};
        tv[3] = '{32'h180, 32'h281, 16'd2, 1'b0, 1'b1, 0, 16'd0};
        tv[4] = '{32'h140, 32'h240, 16'd1, 1'b0, 1'b0, 3, 16'd1};
        tv[5] = '{32'h160, 32'h2C0, 16'd5, 1'b1, 1'b0, 11, 16'd5};

        #1;
        check("reset outputs",
              {busy_out, done_out, error_out, aborted_out, count_out,
               mem_enable_out, mem_wb_out, mem_addr_out[11:0]}, 0);
        check("reset mem_data", mem_data_out, 0);
        @(negedge clock);
        reset = 1'b0;

        // Abort during the third WRITE of an 8-word copy.
        for (int i = 0; i < 8; i++) poke(32'h040 + 32'(4 * i), srcword(9, i));
        for (int i = 0; i < 9; i++) poke(32'h300 + 32'(4 * i), 32'hDEADBEEF);
        start_copy(32'h040, 32'h300, 16'd8);
        cyc = 1; ab_cyc = 0; done_n = 0; wr_n = 0;
        while (cyc <= 14) begin
            if (aborted_out && ab_cyc == 0) ab_cyc = cyc;
            if (done_out) done_n++;
            if (mem_enable_out && mem_wb_out == 4'hF) wr_n++;
            if (cyc == 7) begin
                check("abort busy", busy_out, 0);
                check("abort count", count_out, 3);
            end
            abort_in = (cyc == 6);
            @(negedge clock);
            cyc++;
        end
        abort_in = 1'b0;
        check("abort pulse cycle", ab_cyc, 7);
        check("abort no done", done_n, 0);
        check("abort writes", wr_n, 3);
        ok = 1'b1;
        for (int i = 0; i < 3; i++)
            if (peek(32'h300 + 32'(4 * i)) !== srcword(9, i)) ok = 1'b0;
        check("abort copied words", ok, 1);
        ok = 1'b1;
        for (int i = 3; i < 9; i++)
            if (peek(32'h300 + 32'(4 * i)) !== 32'hDEADBEEF) ok = 1'b0;
        check("abort tail untouched", ok, 1);

        // Reset in the second WRITE of a 4-word copy.
        for (int i = 0; i < 4; i++) poke(32'h080 + 32'(4 * i), srcword(8, i));
        for (int i = 0; i < 4; i++) poke(32'h380 + 32'(4 * i), 32'hDEADBEEF);
        start_copy(32'h080, 32'h380, 16'd4);
        repeat (3) @(negedge clock);
        check("pre-reset write mask", mem_wb_out, 4'hF);
        #1 reset = 1'b1;
        #1;
        check("midreset outputs",
              {busy_out, done_out, error_out, aborted_out, count_out,
               mem_enable_out, mem_wb_out, mem_addr_out[11:0]}, 0);
        check("midreset mem_data", mem_data_out, 0);
        @(negedge clock);
        reset = 1'b0;
        check("reset word0 written", peek(32'h380), srcword(8, 0));
        check("reset word1 lost", peek(32'h384), 32'hDEADBEEF);

        for (int v = 0; v < 6; v++) run_vec(v);
        check("byte 0x200", m[10'h200], 8'h44);
        check("byte 0x20F", m[10'h20F], 8'hDD);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
